// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//
// Time-set sequencer for an HH:MM:SS day counter. Two raw push-buttons are
// synchronised and debounced. The mode button walks the sequence
// RUN -> SET_HRS -> SET_MINS -> COMMIT -> RUN. The increment button edits a
// shadow copy of hours/minutes, with auto-repeat while it is held.
// COMMIT issues a one-cycle load of the edited time into the counters. The
// field being edited blinks through a per-digit blank mask.
//
// Ports
//   Clock_50MHz  in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high
//   mode_btn     in   1  raw mode button, active-high, asynchronous
//   inc_btn      in   1  raw increment button, active-high, asynchronous
//   cur_hrs      in   5  live hour count (0..23)
//   cur_mins     in   6  live minute count (0..59)
//   run_en       out  1  1 = seconds prescaler may count
//   load         out  1  one-cycle load strobe for the counters
//   load_hrs     out  5  hour value to load (the shadow hour register)
//   load_mins    out  6  minute value to load (the shadow minute register)
//   blank        out  6  1 = digit dark; [5:4] hrs, [3:2] mins, [1:0] secs
//   set_state    out  2  00 RUN, 01 SET_HRS, 10 SET_MINS, 11 COMMIT
//
// There are no valid/ready handshakes in this block. Every button event is a
// single-cycle pulse. It is consumed in the cycle it appears, or it is lost.
// ---------------------------------------------------------------------------

// Per-button input path: a 2-flop synchroniser, then a stable-level counter.
// It emits a registered one-cycle evt on an accepted press. With REPEAT_EN
// set, evt also pulses for auto-repeat while the accepted level stays high.
module time_set_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic evt
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] stable_cnt;
    logic [RW-1:0] rep_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            rep_cnt    <= '0;
            evt        <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            evt   <= 1'b0;

            // stable_cnt counts consecutive cycles in which the synchronised
            // level differs from the accepted one. Any return to the
            // accepted level restarts the count.
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync2;
                stable_cnt <= '0;
                if (sync2) begin
                    evt <= 1'b1;
                end
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end

            // rep_cnt is the number of cycles since the press while the
            // level is held. After a repeat, it is rewound so that the next
            // hit comes REPEAT_PERIOD cycles later. A press needs
            // level == 0, so it can never coincide with a repeat.
            if (REPEAT_EN && level) begin
                if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                    evt     <= 1'b1;
                    rep_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end
endmodule

module time_set_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int BLINK_HZ        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       Clock_50MHz,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] cur_hrs,
    input  logic [5:0] cur_mins,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hrs,
    output logic [5:0] load_mins,
    output logic [5:0] blank,
    output logic [1:0] set_state
);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HRS    = 2'b01,
        ST_MINS   = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    state_t        state;
    logic          mode_evt;
    logic          inc_evt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    time_set_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (1'b0),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_mode (
        .clk  (Clock_50MHz),
        .reset(reset),
        .raw  (mode_btn),
        .evt  (mode_evt)
    );

    time_set_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (1'b1),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_inc (
        .clk  (Clock_50MHz),
        .reset(reset),
        .raw  (inc_btn),
        .evt  (inc_evt)
    );

    // The state register is itself the debug/status output.
    assign set_state = state;

    // load_hrs/load_mins are the shadow edit registers. They are loaded on
    // entry to SET_HRS, stepped by inc_evt, and left alone in RUN/COMMIT.
    // blank is registered from the next-cycle phase, so it changes on the
    // same edge as the phase flop.
    always_ff @(posedge Clock_50MHz) begin
        if (reset) begin
            state     <= ST_RUN;
            run_en    <= 1'b1;
            load      <= 1'b0;
            load_hrs  <= '0;
            load_mins <= '0;
            blank     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_RUN: begin
                    run_en <= 1'b1;
                    blank  <= '0;
                    if (mode_evt) begin
                        state     <= ST_HRS;
                        run_en    <= 1'b0;
                        load_hrs  <= (cur_hrs > 5'd23) ? 5'd0 : cur_hrs;
                        load_mins <= (cur_mins > 6'd59) ? 6'd0 : cur_mins;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end
                end

                ST_HRS: begin
                    run_en <= 1'b0;
                    if (mode_evt) begin
                        // mode wins over a coincident inc_evt, which is dropped
                        state     <= ST_MINS;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                        blank     <= '0;
                    end else if (inc_evt) begin
                        load_hrs  <= (load_hrs == 5'd23) ? 5'd0 : load_hrs + 5'd1;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                        blank     <= '0;
                    end else if (blink_cnt == BW'(HALF - 1)) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                        blank     <= {~phase, ~phase, 4'b0000};
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                        blank     <= {phase, phase, 4'b0000};
                    end
                end

                ST_MINS: begin
                    run_en <= 1'b0;
                    if (mode_evt) begin
                        state <= ST_COMMIT;
                        load  <= 1'b1;
                        blank <= '0;
                    end else if (inc_evt) begin
                        load_mins <= (load_mins == 6'd59) ? 6'd0 : load_mins + 6'd1;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                        blank     <= '0;
                    end else if (blink_cnt == BW'(HALF - 1)) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                        blank     <= {2'b00, ~phase, ~phase, 2'b00};
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                        blank     <= {2'b00, phase, phase, 2'b00};
                    end
                end

                ST_COMMIT: begin
                    // A single cycle with load high. Events arriving now are ignored.
                    state  <= ST_RUN;
                    run_en <= 1'b1;
                    blank  <= '0;
                end

                default: begin
                    state  <= ST_RUN;
                    run_en <= 1'b1;
                    blank  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Bench for time_set_ctrl with small timing parameters. A behavioural model
// steps on every rising edge. It recomputes the expected outputs from the
// block's rules:
//   - acceptance window over the raw sample history
//   - repeat schedule measured from the press time
//   - mod-24 / mod-60 edits
//   - blink phase computed from the cycles elapsed since the last clear
// Each cycle, the outputs are compared 1 time unit after the edge. Directed
// sequences add literal expectations that are checked on falling edges.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;
    localparam int D    = 4;
    localparam int CHZ  = 16;
    localparam int BHZ  = 2;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int HALF = CHZ / (2 * BHZ);

    logic       clk;
    logic       reset;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] cur_hrs;
    logic [5:0] cur_mins;
    logic       run_en;
    logic       load;
    logic [4:0] load_hrs;
    logic [5:0] load_mins;
    logic [5:0] blank;
    logic [1:0] set_state;

    int total;
    int bad;

    time_set_ctrl #(
        .CLK_HZ         (CHZ),
        .BLINK_HZ       (BHZ),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .Clock_50MHz(clk),
        .reset      (reset),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .cur_hrs    (cur_hrs),
        .cur_mins   (cur_mins),
        .run_en     (run_en),
        .load       (load),
        .load_hrs   (load_hrs),
        .load_mins  (load_mins),
        .blank      (blank),
        .set_state  (set_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  cyc;
    int  m_st;        // 0 RUN, 1 SET_HRS, 2 SET_MINS, 3 COMMIT
    int  m_eh;
    int  m_em;
    int  m_clr;       // edge index of the last blink clear
    int  m_ptime;     // edge index of the last accepted inc press
    bit  m_acc  [2];
    bit  m_press[2];
    bit  m_rep;
    bit  m_hist [2][D+2];
    bit  m_ready;

    initial begin
        cyc     = 0;
        m_ready = 1'b0;
    end

    always @(posedge clk) begin
        bit ev_mode;
        bit ev_inc;
        bit old_inc_lvl;
        bit flip;
        bit rawb;
        int ph;
        logic [5:0] eb;
        cyc = cyc + 1;
        if (reset) begin
            m_st    = 0;
            m_eh    = 0;
            m_em    = 0;
            m_clr   = cyc;
            m_ptime = -1000000;
            m_rep   = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_acc[b]   = 1'b0;
                m_press[b] = 1'b0;
                for (int i = 0; i < D + 2; i++) m_hist[b][i] = 1'b0;
            end
            m_ready = 1'b1;
        end else begin
            ev_mode = m_press[0];
            ev_inc  = m_press[1] | m_rep;
            case (m_st)
                0: if (ev_mode) begin
                    m_st  = 1;
                    m_eh  = (cur_hrs > 23) ? 0 : int'(cur_hrs);
                    m_em  = (cur_mins > 59) ? 0 : int'(cur_mins);
                    m_clr = cyc;
                end
                1: if (ev_mode) begin
                    m_st  = 2;
                    m_clr = cyc;
                end else if (ev_inc) begin
                    m_eh  = (m_eh + 1) % 24;
                    m_clr = cyc;
                end
                2: if (ev_mode) begin
                    m_st = 3;
                end else if (ev_inc) begin
                    m_em  = (m_em + 1) % 60;
                    m_clr = cyc;
                end
                default: m_st = 0;
            endcase
            old_inc_lvl = m_acc[1];
            m_rep = old_inc_lvl && (cyc - m_ptime >= RD) && ((cyc - m_ptime - RD) % RP == 0);
            for (int b = 0; b < 2; b++) begin
                rawb = (b == 0) ? mode_btn : inc_btn;
                for (int i = 0; i < D + 1; i++) m_hist[b][i] = m_hist[b][i+1];
                m_hist[b][D+1] = rawb;
                // accepted level flips when the D samples just past the
                // synchroniser all disagree with it
                flip = 1'b1;
                for (int i = 0; i < D; i++) if (m_hist[b][i] == m_acc[b]) flip = 1'b0;
                m_press[b] = flip && !m_acc[b];
                if (flip) m_acc[b] = !m_acc[b];
            end
            if (m_press[1]) m_ptime = cyc;
        end
        #1;
        if (m_ready) begin
            ph = ((cyc - m_clr) / HALF) % 2;
            eb = 6'b0;
            if (m_st == 1 && ph == 1) eb = 6'b110000;
            if (m_st == 2 && ph == 1) eb = 6'b001100;
            chk("m_set_state", 32'(set_state), 32'(m_st));
            chk("m_run_en",    32'(run_en),    32'(m_st == 0));
            chk("m_load",      32'(load),      32'(m_st == 3));
            chk("m_load_hrs",  32'(load_hrs),  32'(m_eh));
            chk("m_load_mins", 32'(load_mins), 32'(m_em));
            chk("m_blank",     32'(blank),     32'(eb));
        end
    end

    // ---------------- driver tasks ----------------
    // Raise mode. One cycle before the press takes effect the state is still
    // prev; one cycle later it is nxt. mode is left high on return.
    task automatic mode_go(input logic [1:0] prev, input logic [1:0] nxt);
        mode_btn = 1'b1;
        repeat (D + 2) @(negedge clk);
        chk("mode_before", 32'(set_state), 32'(prev));
        @(negedge clk);
        chk("mode_after", 32'(set_state), 32'(nxt));
    endtask

    task automatic mode_rel();
        mode_btn = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic inc_tap(input int hold);
        inc_btn = 1'b1;
        repeat (hold) @(negedge clk);
        inc_btn = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cur_hrs  = 5'd22;
        cur_mins = 6'd17;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_run_en",    32'(run_en),    32'd1);
        chk("rst_load",      32'(load),      32'd0);
        chk("rst_blank",     32'(blank),     32'd0);
        chk("rst_state",     32'(set_state), 32'd0);
        chk("rst_load_hrs",  32'(load_hrs),  32'd0);
        chk("rst_load_mins", 32'(load_mins), 32'd0);

        // 1: a 3-cycle glitch is rejected; a 10-cycle hold enters SET_HRS
        mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        mode_btn = 1'b0;
        repeat (8) @(negedge clk);
        chk("short_pulse_state", 32'(set_state), 32'd0);
        mode_go(2'b00, 2'b01);
        chk("t1_run_en", 32'(run_en), 32'd0);
        repeat (3) @(negedge clk);
        mode_rel();

        // 2: 22 -> 23 -> 0 -> 1, then commit
        chk("t2_capture", 32'(load_hrs), 32'd22);
        inc_tap(8);
        chk("t2_inc1", 32'(load_hrs), 32'd23);
        inc_tap(8);
        chk("t2_inc2", 32'(load_hrs), 32'd0);
        inc_tap(8);
        chk("t2_inc3", 32'(load_hrs), 32'd1);
        chk("t2_model_eh", 32'(m_eh), 32'd1);
        mode_go(2'b01, 2'b10);
        mode_rel();
        mode_go(2'b10, 2'b11);
        chk("t2_load",      32'(load),      32'd1);
        chk("t2_load_hrs",  32'(load_hrs),  32'd1);
        chk("t2_load_mins", 32'(load_mins), 32'd17);
        @(negedge clk);
        chk("t2_back_run", 32'(set_state), 32'd0);
        chk("t2_run_en",   32'(run_en),    32'd1);
        chk("t2_load_end", 32'(load),      32'd0);
        mode_rel();

        // 3: held inc: press plus repeats at +20, +25 and +30 gives 58 -> 2
        cur_hrs  = 5'd5;
        cur_mins = 6'd58;
        mode_go(2'b00, 2'b01);
        mode_rel();
        mode_go(2'b01, 2'b10);
        mode_rel();
        inc_btn = 1'b1;
        repeat (32) @(negedge clk);
        inc_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("t3_mins", 32'(load_mins), 32'd2);
        chk("t3_model_em", 32'(m_em), 32'd2);
        mode_go(2'b10, 2'b11);
        chk("t3_load",      32'(load),      32'd1);
        chk("t3_load_mins", 32'(load_mins), 32'd2);
        chk("t3_load_hrs",  32'(load_hrs),  32'd5);
        mode_rel();

        // 4: blink in SET_HRS, restarted by inc_evt
        cur_hrs  = 5'd10;
        cur_mins = 6'd30;
        mode_go(2'b00, 2'b01);
        mode_btn = 1'b0;
        chk("t4_blank_e0", 32'(blank), 32'd0);
        repeat (4) @(negedge clk);
        chk("t4_blank_e4", 32'(blank), 32'h30);
        repeat (4) @(negedge clk);
        chk("t4_blank_e8", 32'(blank), 32'd0);
        inc_btn = 1'b1;
        repeat (D + 3) @(negedge clk);
        chk("t4_blank_clr", 32'(blank),    32'd0);
        chk("t4_hrs",       32'(load_hrs), 32'd11);
        repeat (3) @(negedge clk);
        chk("t4_blank_c3", 32'(blank), 32'd0);
        @(negedge clk);
        chk("t4_blank_c4", 32'(blank), 32'h30);
        inc_btn = 1'b0;
        repeat (D + 6) @(negedge clk);

        // 5: simultaneous mode and inc: mode wins and the inc is dropped
        inc_btn = 1'b1;
        mode_go(2'b01, 2'b10);
        chk("t5_hrs", 32'(load_hrs), 32'd11);
        inc_btn = 1'b0;
        mode_rel();

        // 6: reset mid-edit discards the edit with no load pulse
        inc_tap(8);
        chk("t6_mins", 32'(load_mins), 32'd31);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_state",  32'(set_state), 32'd0);
        chk("t6_run_en", 32'(run_en),    32'd1);
        chk("t6_blank",  32'(blank),     32'd0);
        chk("t6_load",   32'(load),      32'd0);
        chk("t6_mins0",  32'(load_mins), 32'd0);
        repeat (20) @(negedge clk);

        // random phase: button levels, live time values (including out of
        // range values) and occasional resets, all checked by the model
        for (int it = 0; it < 400; it++) begin
            mode_btn = ($urandom_range(0, 3) == 0);
            inc_btn  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cur_hrs  = 5'($urandom_range(0, 31));
                cur_mins = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
